// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SERIAL_ADD_W = 8;

endpackage

// File: rtl/serial_fa_slice.sv
// Combinational 1-bit full adder shared by the serial sequencer.
module serial_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice per clock, LSB first.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' port for a - b (two's complement).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W     = SERIAL_ADD_W,
    parameter int CNT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    state_t           r_state;
    logic [W-1:0]     r_sha;
    logic [W-1:0]     r_shb;
    logic [W-2:0]     r_shs;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_sum;
    logic             r_cout;

    logic             w_sub;
    logic             w_sub_load;
    logic             w_bin;
    logic             w_s;
    logic             w_co;
    logic [W-1:0]     w_asm;

`ifdef SERIAL_ADD_SUB_EN
    logic r_sub;
    assign w_sub      = r_sub;
    assign w_sub_load = sub;
`else
    assign w_sub      = 1'b0;
    assign w_sub_load = 1'b0;
`endif

    // Subtraction inverts B at the slice input; the +1 comes from the carry FF.
    assign w_bin = r_shb[0] ^ w_sub;

    serial_fa_slice u_slice (
        .a  (r_sha[0]),
        .b  (w_bin),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // The new bit enters at the MSB; after W shifts the word is fully assembled.
    assign w_asm = {w_s, r_shs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sha   <= '0;
            r_shb   <= '0;
            r_shs   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sha   <= a;
                        r_shb   <= b;
                        r_carry <= cin | w_sub_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
`ifdef SERIAL_ADD_SUB_EN
                        r_sub   <= sub;
`endif
                    end
                end
                RUN: begin
                    r_sha   <= r_sha >> 1;
                    r_shb   <= r_shb >> 1;
                    r_shs   <= w_asm[W-1:1];
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Publish on the final bit so sum/cout stay frozen while running.
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_asm;
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (W=8); define SERIAL_ADD_SUB_EN to cover subtraction.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Runs one operation; optionally pulses start with other operands at sample pulse_at.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input logic is, input int pulse_at,
                          output int busy_n, output int done_at, output int done_n,
                          output logic [7:0] rs, output logic rc, output logic held_ok);
        logic [7:0] prev_s;
        logic       prev_c;
        @(negedge clk);
        prev_s = sum;
        prev_c = cout;
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~ic; sub = ~is;
        busy_n = 0; done_at = 0; done_n = 0; rs = '0; rc = 1'b0; held_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = i;
                rs = sum;
                rc = cout;
            end else if (done_n == 0 && (sum !== prev_s || cout !== prev_c)) begin
                held_ok = 1'b0;
            end
            if (i == pulse_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int         busy_n, done_at, done_n;
        logic [7:0] rs;
        logic       rc, held_ok;
        int         n_done, first_at, last_at;
        logic       gap_ok, seen_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum",  sum,  0);
        chk("reset_cout", cout, 0);
        rst = 1'b0;

        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h30, 8'h10, 1'b0, 1'b1, 8'h20, 1'b1});
`endif

        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, 0,
                   busy_n, done_at, done_n, rs, rc, held_ok);
            chk($sformatf("v%0d_busy_cycles", k), busy_n, 9);
            chk($sformatf("v%0d_done_at", k), done_at, 9);
            chk($sformatf("v%0d_done_count", k), done_n, 1);
            chk($sformatf("v%0d_sum", k), rs, vecs[k].s);
            chk($sformatf("v%0d_cout", k), rc, vecs[k].co);
            chk($sformatf("v%0d_sum_held", k), held_ok, 1);
        end

        // start pulsed mid-run must be ignored
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 4, busy_n, done_at, done_n, rs, rc, held_ok);
        chk("busy_start_done_count", done_n, 1);
        chk("busy_start_done_at", done_at, 9);
        chk("busy_start_sum", rs, 8'h30);
        chk("busy_start_cout", rc, 0);
        chk("busy_start_held", held_ok, 1);
        chk("busy_start_busy_cycles", busy_n, 9);

        // asynchronous reset four cycles into RUN
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_done", done, 0);
        chk("midrun_rst_sum",  sum,  0);
        chk("midrun_rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("midrun_rst_no_done", seen_done, 0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, busy_n, done_at, done_n, rs, rc, held_ok);
        chk("after_rst_sum", rs, 8'h02);
        chk("after_rst_done_at", done_at, 9);

        // start held high: re-accepted every W+2 cycles
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; sub = 1'b0; start = 1'b1;
        n_done = 0; first_at = 0; last_at = 0; gap_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_at == 0) first_at = i;
                else if (i - last_at != 10) gap_ok = 1'b0;
                last_at = i;
                chk($sformatf("held_start_sum%0d", n_done), sum, 8'h07);
            end
        end
        start = 1'b0;
        chk("held_start_done_count", n_done, 3);
        chk("held_start_first_done", first_at, 9);
        chk("held_start_spacing", gap_ok, 1);
        repeat (12) @(negedge clk);
        chk("held_start_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: accepts two W-bit operands plus carry-in on a start pulse.
- Drives a single 1-bit full-adder slice once per clock, LSB first, with a registered carry between bits.
- Returns the W-bit sum and carry-out with a one-cycle done pulse.
- Sits between a requesting controller and the shared 1-bit adder datapath; trades latency for area.

Parameters:
W, 8, operand/result width in bits (W >= 2)
CNT_W, $clog2(W), bit-index counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
a  in  W  operand A; captured on accepted start
b  in  W  operand B; captured on accepted start
cin  in  1  carry-in; captured on accepted start
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when result is valid
sum  out  W  result; held stable from done until the next accepted start
cout  out  1  final carry-out; held like sum

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, bit counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge: load shift regs with a and b, carry FF with cin, counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Slice inputs = shA[0], shB[0], carry FF.
  - Slice sum bit shifts into the MSB of the sum shift register; shA and shB shift right.
  - Carry FF takes the slice carry; counter increments.
  - When counter == W-1 at the edge: go to DONE.
- DONE:
  - done=1 for exactly this cycle; sum = assembled register, cout = carry FF.
  - Next cycle: IDLE.
- Latency: start accepted at edge N; done=1 during cycle N+W+1 (W RUN cycles + 1 DONE cycle). Throughput: one operation per W+2 cycles.
- start while busy=1 (RUN or DONE): ignored; no queueing, no effect on the operation in flight.
- start held high continuously: re-accepted on the first IDLE cycle after DONE.
- sum/cout must not change during RUN. Internal shift register is separate from the sum output register; sum/cout update only on entry to DONE.
- Arithmetic: modulo 2^W sum; cout is carry out of bit W-1. Operand changes after the accepting edge have no effect.
- Reset asserted mid-RUN: operation aborted, outputs return to reset values, no done pulse.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands on accepted start.
  - sub=1 → result = a - b: b is inverted bit-by-bit at the slice input; carry FF loads (cin | sub).
  - cout=1 means no borrow.
  - sub=0 behaves identically to the macro-undefined build.
- Undefined: port sub absent; addition only.

Decomposition:
- Package serial_add_pkg:
  - state enum typedef {IDLE, RUN, DONE}, 2 bits.
  - Default width constant SERIAL_ADD_W=8.
- Sub-module: serial_fa_slice, the combinational 1-bit full adder (a, b, ci → s, co).
  - Instantiated once; the controller owns all registers.

Test Plan:
- W=8, a=8'h5A, b=8'h3C, cin=0, start 1 cycle → busy=1 for 9 cycles; done pulses 9 cycles after start edge with sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; then a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0.
- Start a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'hFF during RUN → single done, sum=8'h30; sum/cout unchanged until that done.
- Assert rst 4 cycles into RUN → busy, done, sum, cout all 0 immediately; after release, a new operation 8'h01+8'h01 gives sum=8'h02.
- start held high for 30 cycles with fixed a=8'h03, b=8'h04 → done every 10 cycles, sum=8'h07 each time.
- SERIAL_ADD_SUB_EN defined, sub=1:
  - a=8'h05, b=8'h07 → sum=8'hFE, cout=0.
  - a=8'h07, b=8'h05 → sum=8'h02, cout=1.
